nvme_cpl_tracker: RTL and testbench

Parametrised per-action NVMe completion tracker. It sits between the completion-queue write path of the rx buffer and the action-side completion FIFOs. It stores each I/O completion in a per-action ring indexed by request id, and retires entries strictly in request order through a pop handshake. Compared with the previous tracker it adds:
- configurable action count and ring depth;
- a full 15-bit status return per entry;
- per-action flush;
- per-action outstanding counts;
- a saturating error counter with first-error capture.

---
 rtl/nvme_track_pkg.sv | 24 ++
 rtl/nvme_track_ram.sv | 33 +++
 rtl/nvme_cpl_tracker.sv | 202 ++++++++++++++++++++
 tb/tb_nvme_cpl_tracker.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvme_track_pkg.sv
// nvme_track_pkg: shared field layout, ring entry type and pop FSM states
// for the per-action completion tracker.
package nvme_track_pkg;

    localparam int CID_OFF    = 96;
    localparam int CID_W      = 16;
    localparam int CID_Q_OFF  = 0;
    localparam int STATUS_OFF = 113;
    localparam int STATUS_W   = 15;

    typedef struct packed {
        logic                valid;
        logic [STATUS_W-1:0] status;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RSP,
        S_LOOK,
        S_FLUSH
    } state_t;

endpackage

// File: rtl/nvme_track_ram.sv
// nvme_track_ram: dual-port ring store, read-and-clear on port A, write on port B.
// Port B wins address collisions and is forwarded onto the port A read data.
module nvme_track_ram
    import nvme_track_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          axi_aclk,
    input  logic          a_en,
    input  logic          a_clr,
    input  logic [AW-1:0] a_addr,
    output entry_t        a_data,
    input  logic          b_en,
    input  logic [AW-1:0] b_addr,
    input  entry_t        b_data
);

    entry_t mem [2**AW];
    logic   coll;

    assign coll = b_en && (b_addr == a_addr);

    always_ff @(posedge axi_aclk) begin
        if (a_en) begin
            a_data <= coll ? b_data : mem[a_addr];
            if (a_clr && !coll)
                mem[a_addr] <= '0;
        end
        if (b_en)
            mem[b_addr] <= b_data;
    end

endmodule

// File: rtl/nvme_cpl_tracker.sv
// nvme_cpl_tracker: per-action NVMe completion rings, retired in request order
// through a pop handshake, with flush, occupancy counts and error capture.
module nvme_cpl_tracker
    import nvme_track_pkg::*;
#(
    parameter int                   ACT_BITS      = 4,
    parameter int                   DEPTH         = 16,
    parameter int                   REQ_BITS      = 8,
    parameter int                   Q_BITS        = 4,
    parameter logic [2**Q_BITS-1:0] ADMIN_Q_MASK  = 16'h0101,
    parameter int                   CQ_ADDR_LIMIT = 64,
    localparam int                  NACT          = 2**ACT_BITS,
    localparam int                  IDX           = $clog2(DEPTH),
    localparam int                  CW            = IDX + 1,
    localparam int                  AW            = ACT_BITS + IDX
) (
    input  logic                 axi_aclk,
    input  logic                 axi_aresetn,
    input  logic                 rx_write_valid,
    input  logic [9:0]           rx_waddr,
    input  logic [127:0]         rx_wdata,
    output logic                 init_done,
    input  logic                 pop_req,
    input  logic [ACT_BITS-1:0]  pop_action,
    output logic                 pop_ready,
    output logic                 pop_done,
    output logic                 pop_hit,
    output logic [14:0]          pop_status,
    output logic [NACT-1:0]      head_ready,
    output logic [NACT*CW-1:0]   act_count,
    input  logic                 flush_req,
    input  logic [ACT_BITS-1:0]  flush_action,
    output logic                 overflow,
    output logic                 flush_drop,
    input  logic                 err_clear,
    output logic                 err_valid,
    output logic [127:0]         err_data,
    output logic [15:0]          err_count
);

    localparam int REQ_OFF = CID_W - REQ_BITS;

    state_t                state;
    logic [AW-1:0]         init_addr;
    logic [ACT_BITS-1:0]   pa, fl_act;
    logic [IDX-1:0]        fl_idx;
    logic [IDX-1:0]        head [NACT];
    logic [CW-1:0]         cnt  [NACT];
    logic [NACT*DEPTH-1:0] valid_bm;
    logic                  wr_pend;
    logic [AW-1:0]         wr_addr;
    entry_t                wr_data;

    logic [Q_BITS-1:0]     q;
    logic [ACT_BITS-1:0]   act;
    logic [IDX-1:0]        idx;
    logic [STATUS_W-1:0]   st;
    logic [AW-1:0]         waddr, look_addr;
    logic                  acc, io, pop_go, flush_go, fl_hit, wr, hit, rd_hit;
    logic                  a_en, a_clr, b_en;
    logic [AW-1:0]         a_addr, b_addr;
    entry_t                a_data, b_data;

    assign q         = rx_wdata[CID_OFF+CID_Q_OFF +: Q_BITS];
    assign act       = rx_wdata[CID_OFF+CID_Q_OFF+Q_BITS +: ACT_BITS];
    assign idx       = rx_wdata[CID_OFF+REQ_OFF +: IDX];
    assign st        = rx_wdata[STATUS_OFF +: STATUS_W];
    assign waddr     = {act, idx};
    assign look_addr = {pa, head[pa]};

    assign acc      = rx_write_valid && (32'(rx_waddr) < CQ_ADDR_LIMIT) && init_done;
    assign io       = !ADMIN_Q_MASK[q];
    assign pop_go   = pop_ready && pop_req;
    assign flush_go = pop_ready && flush_req && !pop_req;
    // a flush being accepted this cycle already owns its action
    assign fl_hit   = (state == S_FLUSH && act == fl_act) || (flush_go && act == flush_action);
    assign wr       = acc && io && !fl_hit;
    assign hit      = head_ready[pa];
    assign rd_hit   = state == S_RD && hit;

    always_comb begin
        a_en   = rd_hit || state == S_RSP || state == S_FLUSH;
        a_clr  = state != S_RSP;
        a_addr = state == S_FLUSH ? {fl_act, fl_idx} : look_addr;
        b_en   = !init_done || wr_pend;
        b_addr = init_done ? wr_addr : init_addr;
        b_data = init_done ? wr_data : '0;
    end

    always_comb begin
        pop_ready  = state == S_IDLE && init_done;
        pop_done   = (state == S_RD && !hit) || state == S_RSP;
        pop_hit    = state == S_RSP;
        pop_status = pop_hit ? a_data.status : '0;
        for (int i = 0; i < NACT; i++)
            act_count[i*CW +: CW] = cnt[i];
    end

    nvme_track_ram #(.AW(AW)) u_ram (
        .axi_aclk (axi_aclk),
        .a_en     (a_en),
        .a_clr    (a_clr),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .b_en     (b_en),
        .b_addr   (b_addr),
        .b_data   (b_data)
    );

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state      <= S_IDLE;
            init_done  <= 1'b0;
            init_addr  <= '0;
            pa         <= '0;
            fl_act     <= '0;
            fl_idx     <= '0;
            valid_bm   <= '0;
            wr_pend    <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            head_ready <= '0;
            overflow   <= 1'b0;
            flush_drop <= 1'b0;
            err_valid  <= 1'b0;
            err_data   <= '0;
            err_count  <= '0;
            for (int i = 0; i < NACT; i++) begin
                head[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            if (!init_done) begin
                init_addr <= init_addr + 1'b1;
                init_done <= &init_addr;
            end
            wr_pend <= wr;
            wr_addr <= waddr;
            wr_data <= {1'b1, st};
            case (state)
                S_IDLE: begin
                    if (pop_go) begin
                        state <= S_RD;
                        pa    <= pop_action;
                    end else if (flush_go) begin
                        state  <= S_FLUSH;
                        fl_act <= flush_action;
                        fl_idx <= '0;
                    end
                end
                S_RD: begin
                    state <= hit ? S_RSP : S_IDLE;
                    if (hit) begin
                        head_ready[pa]      <= 1'b0;
                        head[pa]            <= head[pa] + 1'b1;
                        cnt[pa]             <= cnt[pa] - 1'b1;
                        valid_bm[look_addr] <= 1'b0;
                    end
                end
                S_RSP: state <= S_LOOK;
                S_LOOK: begin
                    // the read was issued before a pending port-B write landed
                    head_ready[pa] <= (b_en && b_addr == look_addr) ? b_data.valid : a_data.valid;
                    state          <= S_IDLE;
                end
                S_FLUSH: begin
                    valid_bm[{fl_act, fl_idx}] <= 1'b0;
                    fl_idx                     <= fl_idx + 1'b1;
                    if (&fl_idx) begin
                        head[fl_act]       <= '0;
                        cnt[fl_act]        <= '0;
                        head_ready[fl_act] <= 1'b0;
                        state              <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (wr) begin
                valid_bm[waddr] <= 1'b1;
                overflow        <= overflow | valid_bm[waddr];
                cnt[act]        <= cnt[act] + CW'(1) - CW'(rd_hit && act == pa);
                if (idx == head[act] && !(rd_hit && act == pa))
                    head_ready[act] <= 1'b1;
            end
            if (acc && io && fl_hit)
                flush_drop <= 1'b1;
            if (err_clear) begin
                err_valid <= 1'b0;
                err_data  <= '0;
                err_count <= '0;
            end
            if (acc && st != '0) begin
                err_count <= err_clear ? 16'd1 : (&err_count ? err_count : err_count + 16'd1);
                if (err_clear || !err_valid) begin
                    err_valid <= 1'b1;
                    err_data  <= rx_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_nvme_cpl_tracker.sv
// tb_nvme_cpl_tracker: directed scenarios for the completion tracker with
// hand-computed expectations (ACT_BITS=4, DEPTH=16).
module tb_nvme_cpl_tracker;

    logic         axi_aclk = 1'b0;
    logic         axi_aresetn = 1'b0;
    logic         rx_write_valid = 1'b0;
    logic [9:0]   rx_waddr = '0;
    logic [127:0] rx_wdata = '0;
    logic         init_done;
    logic         pop_req = 1'b0;
    logic [3:0]   pop_action = '0;
    logic         pop_ready, pop_done, pop_hit;
    logic [14:0]  pop_status;
    logic [15:0]  head_ready;
    logic [79:0]  act_count;
    logic         flush_req = 1'b0;
    logic [3:0]   flush_action = '0;
    logic         overflow, flush_drop;
    logic         err_clear = 1'b0;
    logic         err_valid;
    logic [127:0] err_data;
    logic [15:0]  err_count;

    int checks = 0;
    int failures = 0;

    always #5 axi_aclk = ~axi_aclk;

    nvme_cpl_tracker dut (
        .axi_aclk       (axi_aclk),
        .axi_aresetn    (axi_aresetn),
        .rx_write_valid (rx_write_valid),
        .rx_waddr       (rx_waddr),
        .rx_wdata       (rx_wdata),
        .init_done      (init_done),
        .pop_req        (pop_req),
        .pop_action     (pop_action),
        .pop_ready      (pop_ready),
        .pop_done       (pop_done),
        .pop_hit        (pop_hit),
        .pop_status     (pop_status),
        .head_ready     (head_ready),
        .act_count      (act_count),
        .flush_req      (flush_req),
        .flush_action   (flush_action),
        .overflow       (overflow),
        .flush_drop     (flush_drop),
        .err_clear      (err_clear),
        .err_valid      (err_valid),
        .err_data       (err_data),
        .err_count      (err_count)
    );

    task automatic tick;
        @(negedge axi_aclk);
    endtask

    function automatic logic [127:0] mkw(input int act, input int req, input int st, input int q);
        logic [127:0] w;
        w = '0;
        w[96 +: 16]  = {8'(req), 4'(act), 4'(q)};
        w[113 +: 15] = 15'(st);
        return w;
    endfunction

    function automatic int cnt(input int a);
        return int'(act_count[a*5 +: 5]);
    endfunction

    task automatic cpl(input int act, input int req, input int st, input int q = 1,
                       input int addr = 0, input logic clr = 1'b0);
        rx_write_valid = 1'b1;
        rx_waddr       = 10'(addr);
        rx_wdata       = mkw(act, req, st, q);
        err_clear      = clr;
        tick;
        rx_write_valid = 1'b0;
        err_clear      = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (pop_ready !== 1'b1 && n < 100) begin
            tick;
            n++;
        end
        if (pop_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_ready_timeout: pop_ready=%b after %0d cycles, required 1", nm, pop_ready, n);
        end
    endtask

    task automatic wait_init(input string nm);
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < 400) begin
            tick;
            n++;
        end
        checks++;
        if (init_done !== 1'b1 || n != 256) begin
            failures++;
            $display("FAIL %s_init_latency: init_done=%b after %0d cycles, required 1 after 256", nm, init_done, n);
        end
    endtask

    task automatic do_pop(input int act, input logic eh, input int es, input string nm);
        int k;
        wait_ready(nm);
        pop_req    = 1'b1;
        pop_action = 4'(act);
        tick;
        pop_req = 1'b0;
        k = 1;
        while (pop_done !== 1'b1 && k < 5) begin
            tick;
            k++;
        end
        checks++;
        if (pop_done !== 1'b1 || k != (eh ? 2 : 1) || pop_hit !== eh || pop_status !== 15'(es)) begin
            failures++;
            $display("FAIL %s: done=%b lat=%0d hit=%b status=%h, required done=1 lat=%0d hit=%b status=%h",
                     nm, pop_done, k, pop_hit, pop_status, eh ? 2 : 1, eh, 15'(es));
        end
        wait_ready(nm);
    endtask

    task automatic test_reset;
        int n;
        tick;
        tick;
        checks++;
        if ({init_done, pop_ready, pop_done, pop_hit, pop_status, head_ready, act_count,
             overflow, flush_drop, err_valid, err_data, err_count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: init=%b ready=%b hr=%h cnt=%h ovf=%b fd=%b ev=%b ec=%h, required all 0",
                     init_done, pop_ready, head_ready, act_count, overflow, flush_drop, err_valid, err_count);
        end
        axi_aresetn = 1'b1;
        n = 0;
        while (init_done !== 1'b1 && n < 400) begin
            rx_write_valid = (n == 10);
            rx_wdata       = mkw(3, 0, 1, 1);
            tick;
            n++;
        end
        rx_write_valid = 1'b0;
        checks++;
        if (init_done !== 1'b1 || n != 256) begin
            failures++;
            $display("FAIL init_latency: init_done=%b after %0d cycles, required 1 after 256", init_done, n);
        end
        checks++;
        if (head_ready !== '0 || act_count !== '0 || err_count !== '0 || pop_ready !== 1'b1) begin
            failures++;
            $display("FAIL init_drop: hr=%h cnt=%h ec=%h ready=%b, required 0 0 0 1",
                     head_ready, act_count, err_count, pop_ready);
        end
    endtask

    task automatic test_single;
        cpl(3, 0, 0);
        checks++;
        if (head_ready[3] !== 1'b1 || cnt(3) != 1) begin
            failures++;
            $display("FAIL single_store: hr3=%b cnt3=%0d, required 1 1", head_ready[3], cnt(3));
        end
        do_pop(3, 1'b1, 0, "single_pop");
        checks++;
        if (head_ready[3] !== 1'b0 || cnt(3) != 0) begin
            failures++;
            $display("FAIL single_after: hr3=%b cnt3=%0d, required 0 0", head_ready[3], cnt(3));
        end
    endtask

    task automatic test_lookahead;
        cpl(5, 1, 'h11);
        checks++;
        if (head_ready[5] !== 1'b0 || cnt(5) != 1) begin
            failures++;
            $display("FAIL look_out_of_order: hr5=%b cnt5=%0d, required 0 1", head_ready[5], cnt(5));
        end
        cpl(5, 0, 'h22);
        checks++;
        if (head_ready[5] !== 1'b1 || cnt(5) != 2) begin
            failures++;
            $display("FAIL look_head: hr5=%b cnt5=%0d, required 1 2", head_ready[5], cnt(5));
        end
        do_pop(5, 1'b1, 'h22, "look_pop0");
        checks++;
        if (head_ready[5] !== 1'b1 || cnt(5) != 1) begin
            failures++;
            $display("FAIL look_ahead: hr5=%b cnt5=%0d, required 1 1", head_ready[5], cnt(5));
        end
        do_pop(5, 1'b1, 'h11, "look_pop1");
        do_pop(5, 1'b0, 0, "look_miss");
    endtask

    task automatic test_collision;
        cpl(2, 0, 'h33);
        wait_ready("coll");
        pop_req    = 1'b1;
        pop_action = 4'd2;
        tick;
        pop_req = 1'b0;
        tick;
        checks++;
        if (pop_done !== 1'b1 || pop_hit !== 1'b1 || pop_status !== 15'h33) begin
            failures++;
            $display("FAIL coll_rsp: done=%b hit=%b status=%h, required 1 1 0033", pop_done, pop_hit, pop_status);
        end
        cpl(2, 1, 'h44);
        tick;
        checks++;
        if (pop_ready !== 1'b1 || head_ready[2] !== 1'b1) begin
            failures++;
            $display("FAIL coll_forward: ready=%b hr2=%b, required 1 1", pop_ready, head_ready[2]);
        end
        do_pop(2, 1'b1, 'h44, "coll_pop");
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 15; i++) begin
            cpl(6, i, 0);
            do_pop(6, 1'b1, 0, "wrap_fill");
        end
        err_clear = 1'b1;
        tick;
        err_clear = 1'b0;
        checks++;
        if (err_valid !== 1'b0 || err_count !== 16'd0 || err_data !== '0) begin
            failures++;
            $display("FAIL err_clear: ev=%b ec=%0d, required 0 0", err_valid, err_count);
        end
        cpl(6, 15, 2);
        checks++;
        if (head_ready[6] !== 1'b1 || err_valid !== 1'b1 || err_count !== 16'd1 || err_data !== mkw(6, 15, 2, 1)) begin
            failures++;
            $display("FAIL wrap_err: hr6=%b ev=%b ec=%0d data=%h, required 1 1 1 %h",
                     head_ready[6], err_valid, err_count, err_data, mkw(6, 15, 2, 1));
        end
        cpl(6, 16, 3);
        checks++;
        if (cnt(6) != 2 || err_count !== 16'd2 || err_data !== mkw(6, 15, 2, 1)) begin
            failures++;
            $display("FAIL wrap_second: cnt6=%0d ec=%0d data=%h, required 2 2 first entry", cnt(6), err_count, err_data);
        end
        do_pop(6, 1'b1, 2, "wrap_pop15");
        checks++;
        if (head_ready[6] !== 1'b1) begin
            failures++;
            $display("FAIL wrap_ahead: hr6=%b, required 1", head_ready[6]);
        end
        do_pop(6, 1'b1, 3, "wrap_pop16");
    endtask

    task automatic test_errors;
        cpl(7, 0, 5, 1, 0, 1'b1);
        checks++;
        if (err_valid !== 1'b1 || err_count !== 16'd1 || err_data !== mkw(7, 0, 5, 1)) begin
            failures++;
            $display("FAIL err_clear_race: ev=%b ec=%0d data=%h, required 1 1 %h", err_valid, err_count, err_data, mkw(7, 0, 5, 1));
        end
        cpl(7, 1, 6, 0);
        checks++;
        if (err_count !== 16'd2 || cnt(7) != 1 || err_data !== mkw(7, 0, 5, 1)) begin
            failures++;
            $display("FAIL err_admin: ec=%0d cnt7=%0d, required 2 1", err_count, cnt(7));
        end
        cpl(7, 2, 9, 1, 64);
        checks++;
        if (err_count !== 16'd2 || cnt(7) != 1) begin
            failures++;
            $display("FAIL addr_limit: ec=%0d cnt7=%0d, required 2 1", err_count, cnt(7));
        end
    endtask

    task automatic test_flush;
        cpl(1, 0, 0);
        cpl(1, 3, 0);
        cpl(4, 0, 0);
        checks++;
        if (cnt(1) != 2 || head_ready[1] !== 1'b1 || overflow !== 1'b0 || flush_drop !== 1'b0) begin
            failures++;
            $display("FAIL flush_setup: cnt1=%0d hr1=%b ovf=%b fd=%b, required 2 1 0 0", cnt(1), head_ready[1], overflow, flush_drop);
        end
        wait_ready("flush");
        flush_req    = 1'b1;
        flush_action = 4'd1;
        tick;
        flush_req = 1'b0;
        cpl(1, 5, 0);
        cpl(4, 1, 0);
        checks++;
        if (pop_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_busy: pop_ready=%b, required 0", pop_ready);
        end
        wait_ready("flush_end");
        checks++;
        if (flush_drop !== 1'b1 || cnt(1) != 0 || head_ready[1] !== 1'b0 || cnt(4) != 2 ||
            head_ready[4] !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL flush_result: fd=%b cnt1=%0d hr1=%b cnt4=%0d hr4=%b ovf=%b, required 1 0 0 2 1 0",
                     flush_drop, cnt(1), head_ready[1], cnt(4), head_ready[4], overflow);
        end
        cpl(4, 0, 0);
        checks++;
        if (overflow !== 1'b1 || cnt(4) != 3) begin
            failures++;
            $display("FAIL overflow: ovf=%b cnt4=%0d, required 1 3", overflow, cnt(4));
        end
        do_pop(4, 1'b1, 0, "flush_pop4");
        do_pop(1, 1'b0, 0, "flush_pop1");
    endtask

    task automatic test_reset_mid;
        axi_aresetn = 1'b0;
        #1;
        checks++;
        if ({init_done, pop_ready, head_ready, act_count, overflow, flush_drop, err_valid, err_data, err_count} !== '0) begin
            failures++;
            $display("FAIL mid_reset: init=%b hr=%h cnt=%h ovf=%b fd=%b ev=%b ec=%h, required all 0",
                     init_done, head_ready, act_count, overflow, flush_drop, err_valid, err_count);
        end
        tick;
        axi_aresetn = 1'b1;
        wait_init("mid");
        do_pop(4, 1'b0, 0, "mid_pop");
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single;
        test_lookahead;
        test_collision;
        test_wrap;
        test_errors;
        test_flush;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
